inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL use parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 SHALL have ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets)
rdy  input  1  global ready; 0 freezes all state
stall  input  5  pipeline stall vector; only stall[0] (IF hold) used
use_npc  input  1  redirect from decode, one-cycle pulse
npc_addr  input  32  redirect target (any byte alignment)
mem_busy  input  1  memory port not accepting an address this cycle
mem_din  input  8  read byte, valid cycle after address acceptance
mem_req  output  1  byte read request
mem_addr  output  32  byte read address
if_pc  output  32  address of delivered instruction
if_inst  output  32  delivered instruction, little-endian assembled
stall_req  output  1  fetch incomplete; requests IF_ID bubble

Function
REQ-003 SHALL hold fetch pc, issue counter ic (0..4), receive counter rc (0..4), pending flag pend, flush flag fl, 32-bit assembly register.
REQ-004 SHALL assert mem_req when ic<4 and not in DONE; mem_addr = pc + ic (32-bit wrap).
REQ-005 Address accepted when mem_req=1 and mem_busy=0 and rdy=1: ic increments, pend set for next cycle; otherwise ic holds, mem_addr stable.
REQ-006 Cycle after acceptance with pend=1 and fl=0: mem_din written to assembly byte rc (byte0 -> bits 7:0 ... byte3 -> bits 31:24), rc increments.
REQ-007 FSM states: FETCH (ic<4 or rc<4), DONE; FETCH->DONE at edge where rc becomes 4.
REQ-008 On entry to DONE: if_pc <= pc, if_inst <= assembled word; outputs otherwise hold their last values in all states.
REQ-009 stall_req = 1 in FETCH, 0 in DONE (combinational from state).
REQ-010 DONE with stall[0]=0 at edge: pc <= pc+4, ic,rc <= 0, -> FETCH; minimum latency 5 cycles per instruction with mem_busy=0.
REQ-011 DONE with stall[0]=1: hold state, if_pc/if_inst, mem_req=0.
REQ-012 use_npc=1 (rdy=1) in any state: pc <= npc_addr, ic,rc <= 0, -> FETCH; fl <= pend-to-be (byte accepted this cycle is discarded next cycle); outputs if_pc/if_inst hold.
REQ-013 use_npc in same cycle as FETCH->DONE or DONE->FETCH: redirect wins; no advance to pc+4, no new delivery.
REQ-014 rdy=0: no state change, mem_req=0; memory also frozen, mem_din held until rdy returns.
REQ-015 No instruction SHALL be delivered whose four bytes did not all come from the current pc after its last redirect.

Reset
REQ-016 rst=0 asynchronously: pc=RESET_PC, ic=rc=0, pend=fl=0, state FETCH, if_pc=0, if_inst=0, mem_req=0, mem_addr=0, stall_req=0 while rst=0.
REQ-017 First edge after rst release begins fetch of RESET_PC; reset mid-fetch discards all partial bytes.

Verification
REQ-018 Bench SHALL cover:
- Reset release, memory holds 13 00 00 00 at 0, mem_busy=0 -> mem_addr 0,1,2,3 on consecutive cycles; 5th cycle stall_req=0, if_pc=0, if_inst=32'h00000013; next fetch at 4.
- mem_busy=1 for 3 cycles on byte 2 -> mem_addr stays pc+2, no byte skipped, if_inst correct, delivery 3 cycles later.
- DONE with stall[0]=1 for 4 cycles -> if_pc/if_inst stable, mem_req=0, pc advances only after stall[0]=0.
- use_npc=1, npc_addr=32'h00001002 after 2 bytes accepted -> in-flight byte dropped, next delivered if_pc=32'h00001002 with bytes 1002..1005.
- use_npc coincident with DONE->FETCH edge -> next if_pc = npc_addr, not pc+4.
- rst pulled low mid-fetch at pc=8 -> outputs zero immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: four single-byte reads per instruction, assembled
// little-endian and handed to decode once all four bytes belong to the current pc.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [4:0]  stall,
  input  logic        use_npc,
  input  logic [31:0] npc_addr,
  input  logic        mem_busy,
  input  logic [7:0]  mem_din,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stall_req
);

  typedef enum logic {
    S_FETCH,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [2:0]  r_ic;
  logic [2:0]  r_rc;
  logic        r_pend;
  logic        r_fl;
  logic [31:0] r_asm;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;

  logic        w_issue;
  logic        w_accept;
  logic        w_recv;
  logic        w_unused;

  // Only the IF hold bit of the stall vector matters to this stage.
  assign w_unused  = ^stall[4:1];

  assign w_issue   = (r_state == S_FETCH) && (r_ic < 3'd4);
  assign mem_req   = rst & rdy & w_issue;
  assign mem_addr  = rst ? (r_pc + {29'd0, r_ic}) : 32'd0;
  assign stall_req = rst & (r_state == S_FETCH);
  assign w_accept  = mem_req & ~mem_busy;
  assign w_recv    = r_pend & ~r_fl;

  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;

  // A byte accepted in the same cycle as a redirect still returns next cycle;
  // r_fl marks it so it is dropped instead of landing in the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ic      <= 3'd0;
      r_rc      <= 3'd0;
      r_pend    <= 1'b0;
      r_fl      <= 1'b0;
      r_asm     <= 32'd0;
      r_if_pc   <= 32'd0;
      r_if_inst <= 32'd0;
    end else if (rdy) begin
      r_pend <= w_accept;
      r_fl   <= use_npc & w_accept;
      if (use_npc) begin
        r_pc    <= npc_addr;
        r_ic    <= 3'd0;
        r_rc    <= 3'd0;
        r_state <= S_FETCH;
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_accept) begin
              r_ic <= r_ic + 3'd1;
            end
            if (w_recv) begin
              r_asm[{r_rc[1:0], 3'b000} +: 8] <= mem_din;
              r_rc <= r_rc + 3'd1;
              if (r_rc == 3'd3) begin
                r_state   <= S_DONE;
                r_if_pc   <= r_pc;
                r_if_inst <= {mem_din, r_asm[23:0]};
              end
            end
          end
          S_DONE: begin
            if (!stall[0]) begin
              r_pc    <= r_pc + 32'd4;
              r_ic    <= 3'd0;
              r_rc    <= 3'd0;
              r_state <= S_FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by a random phase, all checked
// against a transaction-level model of which pc should be delivered next.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [4:0]  stall;
  logic        use_npc;
  logic [31:0] npc_addr;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stall_req;

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .stall     (stall),
    .use_npc   (use_npc),
    .npc_addr  (npc_addr),
    .mem_busy  (mem_busy),
    .mem_din   (mem_din),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .stall_req (stall_req)
  );

  logic [7:0]  memArr [0:65535];
  int          total;
  int          bad;
  int          cyc;
  int          deliveries;
  logic        prevStall;
  logic        delivered;
  logic        stepReq;
  logic        stepAcc;
  logic [31:0] stepAddr;
  logic [31:0] expPc;
  logic [31:0] modelIfPc;
  logic [31:0] modelIfInst;
  int          acceptIdx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: one byte returned the cycle after each accepted address, otherwise held.
  always @(posedge clk) begin
    if (mem_req && !mem_busy && rdy) mem_din <= memArr[mem_addr[15:0]];
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return {memArr[16'(a + 32'd3)], memArr[16'(a + 32'd2)],
            memArr[16'(a + 32'd1)], memArr[a[15:0]]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check the request just before the edge,
  // apply redirect to the model at the edge, then look for a new delivery.
  task automatic applyStimulus(input logic iRdy, input logic iUse, input logic [31:0] iNpc,
                               input logic iBusy, input logic iStall);
    rdy      = iRdy;
    use_npc  = iUse;
    npc_addr = iNpc;
    mem_busy = iBusy;
    stall    = {4'($urandom), iStall};
    #1;
    stepReq  = mem_req;
    stepAddr = mem_addr;
    stepAcc  = mem_req && !mem_busy && iRdy;
    if (!iRdy) checkOutput("req_without_rdy", {31'd0, mem_req}, 32'd0);
    if (stall_req === 1'b0) checkOutput("req_in_done", {31'd0, mem_req}, 32'd0);
    if (stepAcc) begin
      checkOutput("accept_addr", mem_addr, expPc + 32'(acceptIdx));
      checkOutput("accept_count_ok", {31'd0, acceptIdx < 4}, 32'd1);
      acceptIdx++;
    end
    @(posedge clk);
    if (iRdy && iUse) begin
      expPc     = iNpc;
      acceptIdx = 0;
    end
    @(negedge clk);
    cyc++;
    delivered = prevStall && (stall_req === 1'b0);
    if (delivered) begin
      checkOutput("deliver_pc", if_pc, expPc);
      checkOutput("deliver_inst", if_inst, word(expPc));
      modelIfPc   = expPc;
      modelIfInst = word(expPc);
      expPc       = expPc + 32'd4;
      acceptIdx   = 0;
      deliveries++;
    end else begin
      checkOutput("if_pc_hold", if_pc, modelIfPc);
      checkOutput("if_inst_hold", if_inst, modelIfInst);
    end
    prevStall = stall_req;
  endtask

  task automatic waitDelivery(input int budget, input logic [31:0] expIfPc, input string tag);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      n++;
    end while (!delivered && n < budget);
    checkOutput({tag, "_delivered"}, {31'd0, delivered}, 32'd1);
    checkOutput({tag, "_pc"}, if_pc, expIfPc);
    checkOutput({tag, "_inst"}, if_inst, word(expIfPc));
  endtask

  task automatic modelReset();
    expPc       = 32'd0;
    acceptIdx   = 0;
    modelIfPc   = 32'd0;
    modelIfInst = 32'd0;
    prevStall   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gap;
    int maxGap;
    int randDel;
    logic rR, rU, rB, rS;
    logic [31:0] rN;

    total = 0; bad = 0; cyc = 0; deliveries = 0;
    delivered = 1'b0;
    for (int i = 0; i < 65536; i++) memArr[i] = 8'($urandom);
    memArr[0] = 8'h13; memArr[1] = 8'h00; memArr[2] = 8'h00; memArr[3] = 8'h00;
    mem_din = 8'h00;
    rst = 1'b0; rdy = 1'b1; stall = 5'd0; use_npc = 1'b0; npc_addr = 32'd0; mem_busy = 1'b0;
    modelReset();

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_inst", if_inst, 32'd0);
    checkOutput("rst_stall_req", {31'd0, stall_req}, 32'd0);
    rst = 1'b1;

    // First fetch from RESET_PC: bytes 0..3 on consecutive cycles, delivery on the 5th
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput("first_acc", {31'd0, stepAcc}, 32'd1);
      checkOutput("first_addr", stepAddr, 32'(i));
      checkOutput("first_stall_req", {31'd0, stall_req}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("first_delivered", {31'd0, delivered}, 32'd1);
    checkOutput("first_if_pc", if_pc, 32'd0);
    checkOutput("first_if_inst", if_inst, 32'h0000_0013);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

    // Busy memory on byte 2 of the fetch at pc=4
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("next_fetch_addr", stepAddr, 32'd4);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("busy_no_acc", {31'd0, stepAcc}, 32'd0);
      checkOutput("busy_addr_held", stepAddr, 32'd6);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("busy_resume_addr", stepAddr, 32'd6);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("busy_not_early", {31'd0, delivered}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("busy_delivered", {31'd0, delivered}, 32'd1);
    checkOutput("busy_if_inst", if_inst, word(32'd4));

    // Hold in DONE under stall[0]
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      checkOutput("stall_req_low", {31'd0, stepReq}, 32'd0);
      checkOutput("stall_if_pc", if_pc, 32'd4);
      checkOutput("stall_done", {31'd0, stall_req}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("stall_then_pc8", stepAddr, 32'd8);

    // Redirect after two bytes accepted
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_1002, 1'b0, 1'b0);
    checkOutput("redir_inflight_acc", {31'd0, stepAcc}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("redir_first_addr", stepAddr, 32'h0000_1002);
    waitDelivery(20, 32'h0000_1002, "redir");

    // Redirect on the DONE->FETCH edge beats pc+4
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    waitDelivery(20, 32'h0000_0200, "redir_done");

    // Redirect on the FETCH->DONE edge suppresses that delivery
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0301, 1'b0, 1'b0);
    checkOutput("redir_fd_no_deliver", {31'd0, delivered}, 32'd0);
    checkOutput("redir_fd_stall_req", {31'd0, stall_req}, 32'd1);
    waitDelivery(20, 32'h0000_0301, "redir_fd");

    // Asynchronous reset mid-fetch at pc=8
    applyStimulus(1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("midrst_mem_addr", mem_addr, 32'd0);
    checkOutput("midrst_if_pc", if_pc, 32'd0);
    checkOutput("midrst_if_inst", if_inst, 32'd0);
    checkOutput("midrst_stall_req", {31'd0, stall_req}, 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    waitDelivery(20, 32'd0, "after_rst");

    // Random traffic: rdy gaps, busy memory, stalls and redirects
    gap = 0; maxGap = 0; randDel = 0;
    for (int i = 0; i < 600; i++) begin
      rR = ($urandom % 10) != 0;
      rB = ($urandom % 3) == 0;
      rS = ($urandom % 3) == 0;
      rU = ($urandom % 25) == 0;
      rN = {16'd0, 16'($urandom)};
      applyStimulus(rR, rU, rN, rB, rS);
      if (delivered) begin
        randDel++;
        gap = 0;
      end else begin
        gap++;
      end
      if (gap > maxGap) maxGap = gap;
    end
    checkOutput("random_progress", {31'd0, maxGap <= 300}, 32'd1);
    checkOutput("random_deliveries", {31'd0, randDel > 10}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
